// File: rtl/sort_host.sv
// Host controller for the 8-entry in-place byte sorter: streams a batch in, starts the sort, streams it back out.
// Optional output order checker is compiled in when SORT_CHECK_EN is defined.
module sort_host (
  input  logic       clk,
  input  logic       nrst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       err,
  output logic       srt_start,
  output logic       srt_wr,
  output logic [2:0] srt_addr,
  output logic [7:0] srt_datain,
  input  logic [7:0] srt_dataout,
  input  logic       srt_ready
);

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    START   = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    RD_ADDR = 3'd4,
    RD_CAP  = 3'd5,
    OUT     = 3'd6
  } state_t;

  state_t     state, state_next;
  logic [2:0] wcnt, wcnt_next;
  logic [2:0] rcnt, rcnt_next;
  logic       out_valid_next;
  logic [7:0] out_data_next;
  logic       in_hs;
  logic       out_hs;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= LOAD;
      wcnt      <= 3'd0;
      rcnt      <= 3'd0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
    end else begin
      state     <= state_next;
      wcnt      <= wcnt_next;
      rcnt      <= rcnt_next;
      out_valid <= out_valid_next;
      out_data  <= out_data_next;
    end
  end

  // nrst gates the write strobe so reset holds srt_wr low even though in_ready follows srt_ready
  assign in_ready = (state == LOAD) & srt_ready;
  assign in_hs    = in_valid & in_ready & nrst;
  assign out_hs   = (state == OUT) & out_ready;
  assign busy     = (state != LOAD) | (wcnt != 3'd0);

  always_comb begin
    state_next     = state;
    wcnt_next      = wcnt;
    rcnt_next      = rcnt;
    out_valid_next = out_valid;
    out_data_next  = out_data;
    srt_wr         = 1'b0;
    srt_start      = 1'b0;
    srt_addr       = 3'd0;
    srt_datain     = 8'd0;
    case (state)
      LOAD: begin
        srt_addr = wcnt;
        if (in_hs) begin
          srt_wr     = 1'b1;
          srt_datain = in_data;
          wcnt_next  = wcnt + 3'd1;
          if (wcnt == 3'd7) state_next = START;
        end
      end
      START: begin
        srt_start  = 1'b1;
        state_next = WAIT_LO;
      end
      WAIT_LO: begin
        if (!srt_ready) state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (srt_ready) begin
          rcnt_next  = 3'd0;
          state_next = RD_ADDR;
        end
      end
      RD_ADDR: begin
        srt_addr   = rcnt;
        state_next = RD_CAP;
      end
      RD_CAP: begin
        // sorter read data for rcnt is valid this cycle
        srt_addr       = rcnt;
        out_data_next  = srt_dataout;
        out_valid_next = 1'b1;
        state_next     = OUT;
      end
      OUT: begin
        srt_addr = rcnt;
        if (out_hs) begin
          out_valid_next = 1'b0;
          rcnt_next      = rcnt + 3'd1;
          state_next     = (rcnt == 3'd7) ? LOAD : RD_ADDR;
        end
      end
      default: state_next = LOAD;
    endcase
  end

`ifdef SORT_CHECK_EN
  logic [7:0] prev;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prev <= 8'd0;
      err  <= 1'b0;
    end else if (state == START) begin
      err <= 1'b0;
    end else if (out_hs) begin
      prev <= out_data;
      if ((rcnt != 3'd0) && (out_data < prev)) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_host.sv
// Self-checking bench for sort_host with a behavioural sorter attached and a queue-based output model.
module tb_sort_host;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       err;
  logic       srt_start;
  logic       srt_wr;
  logic [2:0] srt_addr;
  logic [7:0] srt_datain;
  logic [7:0] srt_dataout;
  logic       srt_ready;

  always #5 clk = ~clk;

  sort_host dut (
    .clk         (clk),
    .nrst        (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .err         (err),
    .srt_start   (srt_start),
    .srt_wr      (srt_wr),
    .srt_addr    (srt_addr),
    .srt_datain  (srt_datain),
    .srt_dataout (srt_dataout),
    .srt_ready   (srt_ready)
  );

  int tests = 0;
  int fails = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- behavioural sorter ----------------
  logic [7:0] mem [8];
  logic [7:0] s_sorted [8];
  logic [7:0] s_tmp;
  logic [4:0] s_cnt;
  logic       s_ready;
  logic [7:0] s_dout;
  bit         bad_sorter = 1'b0;

  always_comb begin
    s_tmp    = 8'd0;
    s_sorted = mem;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (s_sorted[j] > s_sorted[j+1]) begin
          s_tmp         = s_sorted[j];
          s_sorted[j]   = s_sorted[j+1];
          s_sorted[j+1] = s_tmp;
        end
    if (bad_sorter) begin
      s_tmp       = s_sorted[0];
      s_sorted[0] = s_sorted[1];
      s_sorted[1] = s_tmp;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready <= 1'b1;
      s_cnt   <= 5'd0;
      s_dout  <= 8'd0;
    end else begin
      s_dout <= mem[srt_addr];
      if (srt_wr) mem[srt_addr] <= srt_datain;
      if (s_ready && srt_start) begin
        s_ready <= 1'b0;
        s_cnt   <= 5'(3 + ($urandom % 8));
      end else if (!s_ready) begin
        if (s_cnt == 5'd0) begin
          mem     <= s_sorted;
          s_ready <= 1'b1;
        end else begin
          s_cnt <= s_cnt - 5'd1;
        end
      end
    end
  end

  assign srt_ready   = s_ready;
  assign srt_dataout = s_dout;

  // ---------------- reference model + compare process ----------------
  logic [7:0] batch [$];
  logic [7:0] expq [$];
  logic [7:0] got [$];
  int         wexp = 0;
  int         ocnt = 0;
  int         starts = 0;
  bit         busy_m = 1'b0;
  bit         err_m = 1'b0;
  logic [7:0] prev_m = 8'd0;
  bit         hold_prev = 1'b0;
  logic [7:0] held = 8'd0;
  logic [7:0] e;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_flags", 32'({out_valid, busy, srt_wr, srt_start, err}), 32'd0);
        chk("reset_data", 32'({out_data, srt_addr, srt_datain}), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'(srt_ready));
        batch.delete(); expq.delete();
        wexp = 0; ocnt = 0; starts = 0; busy_m = 0; err_m = 0; prev_m = 0; hold_prev = 0;
      end else begin
        chk("in_ready", 32'(in_ready), 32'((wexp < 8) && srt_ready));
        chk("busy", 32'(busy), 32'(busy_m));
        chk("err", 32'(err), 32'(err_m));
        chk("wr_start_excl", 32'(srt_wr & srt_start), 32'd0);
        chk("srt_wr", 32'(srt_wr), 32'(in_valid & in_ready));
        if (in_valid && in_ready) begin
          chk("wr_addr", 32'(srt_addr), 32'(wexp));
          chk("wr_data", 32'(srt_datain), 32'(in_data));
          batch.push_back(in_data);
          wexp++;
          busy_m = 1'b1;
          if (wexp == 8) begin
            expq = batch;
            expq.sort();
            if (bad_sorter) begin
              e = expq[0]; expq[0] = expq[1]; expq[1] = e;
            end
            starts = 0;
          end
        end
        if (srt_start) begin
          starts++;
`ifdef SORT_CHECK_EN
          err_m = 1'b0;
`endif
        end
        if (hold_prev) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", 32'(out_data), 32'(held));
        end
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            chk("unexpected_out", 32'd1, 32'd0);
          end else begin
            e = expq.pop_front();
            chk($sformatf("out_data[%0d]", ocnt), 32'(out_data), 32'(e));
          end
          got.push_back(out_data);
`ifdef SORT_CHECK_EN
          if (ocnt > 0 && out_data < prev_m) err_m = 1'b1;
          prev_m = out_data;
`endif
          ocnt++;
          if (ocnt == 8) begin
            chk("start_pulses", 32'(starts), 32'd1);
            ocnt = 0; wexp = 0; busy_m = 0;
            batch.delete();
          end
        end
        hold_prev = out_valid && !out_ready;
        held      = out_data;
      end
    end
  end

  // ---------------- consumer ----------------
  int ready_mode = 0;
  int stall_idx = -1;
  int stall_left = 0;
  bit stall_done = 1'b0;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (!stall_done && stall_idx == got.size() && out_valid) begin
        stall_done = 1'b1;
        stall_left = 4;
        out_ready  = 1'b0;
      end else begin
        out_ready = (ready_mode == 0) ? 1'b1 : (($urandom % 2) == 1);
      end
    end
  end

  // ---------------- driver ----------------
  logic [7:0] bvals [8];
  logic [7:0] lit [8];

  task automatic send_batch(input int gap);
    bit hs;
    int tmo;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = bvals[i];
      tmo = 0;
      hs  = 1'b0;
      while (!hs && tmo < 2000) begin
        @(negedge clk);
        hs = in_ready;
        @(posedge clk); #1;
        tmo++;
      end
      if (!hs) chk("in_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_out(input int n);
    int tmo = 0;
    while (got.size() < n && tmo < 5000) begin
      @(posedge clk); #1;
      tmo++;
    end
    if (got.size() < n) chk("out_timeout", 32'(got.size()), 32'(n));
  endtask

  task automatic check_lit(input string name);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s[%0d]", name, i), 32'(got[i]), 32'(lit[i]));
  endtask

  task automatic set_vals(input logic [63:0] v);
    for (int i = 0; i < 8; i++) bvals[i] = v[63 - 8*i -: 8];
  endtask

  task automatic set_lit(input logic [63:0] v);
    for (int i = 0; i < 8; i++) lit[i] = v[63 - 8*i -: 8];
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready_lit", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // back-to-back load of a mixed batch
    set_vals(64'h05_03_07_01_08_02_06_04);
    set_lit(64'h01_02_03_04_05_06_07_08);
    got.delete();
    send_batch(0);
    wait_out(8);
    check_lit("b2b");
    @(negedge clk);
    chk("busy_after_batch", 32'(busy), 32'd0);
    chk("err_after_batch", 32'(err), 32'd0);

    // all-equal bytes with input gaps
    set_vals(64'hFF_FF_FF_FF_FF_FF_FF_FF);
    set_lit(64'hFF_FF_FF_FF_FF_FF_FF_FF);
    got.delete();
    @(posedge clk); #1;
    send_batch(2);
    wait_out(8);
    check_lit("dup_ff");

    // consumer backpressure at word index 3
    set_vals(64'h05_03_07_01_08_02_06_04);
    set_lit(64'h01_02_03_04_05_06_07_08);
    got.delete();
    stall_done = 1'b0;
    stall_idx  = 3;
    send_batch(0);
    wait_out(8);
    check_lit("stall");
    stall_idx = -1;

    // reset while waiting for the sorter
    set_vals(64'h01_02_03_04_05_06_07_08);
    got.delete();
    send_batch(0);
    begin
      int tmo = 0;
      while (srt_ready && tmo < 100) begin @(posedge clk); #1; tmo++; end
      if (srt_ready) chk("sorter_busy_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    got.delete();
    set_vals(64'h08_07_06_05_04_03_02_01);
    set_lit(64'h01_02_03_04_05_06_07_08);
    send_batch(0);
    wait_out(8);
    check_lit("after_reset");

`ifdef SORT_CHECK_EN
    // misordering sorter raises the sticky order error
    bad_sorter = 1'b1;
    set_vals(64'h01_02_03_04_05_06_07_08);
    set_lit(64'h02_01_03_04_05_06_07_08);
    got.delete();
    send_batch(0);
    wait_out(8);
    check_lit("badsort");
    @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    bad_sorter = 1'b0;
    got.delete();
    @(posedge clk); #1;
    send_batch(0);
    begin
      int tmo = 0;
      while (!srt_start && tmo < 100) begin @(posedge clk); #1; tmo++; end
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_cleared_by_start", 32'(err), 32'd0);
    wait_out(8);
`endif

    // randomized batches with random gaps and backpressure
    ready_mode = 1;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 8; i++)
        bvals[i] = (b % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      got.delete();
      send_batch(int'($urandom_range(0, 2)));
      wait_out(8);
    end
    ready_mode = 0;
    repeat (3) begin @(posedge clk); #1; end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sort_host.md
# sort_host

Host-side controller for the 8-entry in-place byte sorter. It accepts eight bytes on a valid/ready input stream and writes them into the sorter's memory through the sorter's load port. It then pulses the sorter's start, waits for the sort to finish, and reads the eight sorted bytes back onto a valid/ready output stream. It sits between a streaming producer/consumer and the sorter, and is the only master of the sorter's `wr`/`addr`/`datain`/`start` pins.

## Interface
- No parameters. Depth is fixed at 8 words and width at 8 bits, matching the sorter.
- clk  input  1  rising-edge clock, shared with the sorter
- nrst  input  1  asynchronous active-low reset, shared with the sorter
- in_valid  input  1  producer has a byte on in_data
- in_data  input  8  byte to load
- in_ready  output  1  block accepts a byte this cycle
- out_valid  output  1  out_data holds a sorted byte
- out_data  output  8  sorted byte, ascending order, index 0 first
- out_ready  input  1  consumer accepts out_data
- busy  output  1  high from the first accepted input byte until the eighth output handshake
- err  output  1  order-check flag (see Configuration)
- srt_start  output  1  start pulse to the sorter
- srt_wr  output  1  sorter write enable
- srt_addr  output  3  sorter address
- srt_datain  output  8  sorter write data
- srt_dataout  input  8  sorter read data, valid one cycle after srt_addr is presented with srt_wr=0
- srt_ready  input  1  sorter idle flag

## Operation
- States: LOAD, START, WAIT_LO, WAIT_HI, RD_ADDR, RD_CAP, OUT.
- LOAD
  - in_ready = srt_ready.
  - A handshake is in_valid & in_ready. On a handshake: srt_wr=1, srt_addr=wcnt, srt_datain=in_data (combinational pass-through), and wcnt increments.
  - Handshake with wcnt==7 → START, wcnt wraps to 0.
  - srt_wr=0 on every non-handshake cycle.
- START
  - srt_start=1 for exactly one cycle, with srt_wr=0.
  - → WAIT_LO.
- WAIT_LO: stay until srt_ready==0, then → WAIT_HI.
- WAIT_HI: stay until srt_ready==1, then → RD_ADDR with rcnt=0.
- RD_ADDR: srt_addr=rcnt, srt_wr=0; → RD_CAP.
- RD_CAP
  - srt_addr is held at rcnt.
  - At the clock edge: out_data <= srt_dataout, out_valid <= 1.
  - → OUT.
- OUT
  - out_valid=1 and out_data is held stable until out_ready.
  - On the handshake: out_valid <= 0, rcnt increments.
  - rcnt==7 → LOAD; otherwise → RD_ADDR.
- Outside LOAD: in_ready=0 and in_valid is ignored.
- Outside OUT: out_ready is ignored.
- srt_wr and srt_start are never high in the same cycle.
- busy = (state != LOAD) | (wcnt != 0).

## Timing
- Reset values: state=LOAD, wcnt=rcnt=0, out_valid=0, out_data=0, srt_start=0, srt_wr=0, srt_addr=0, srt_datain=0, busy=0, err=0.
- in_ready=srt_ready while in reset.
- Load: minimum 8 cycles with in_valid held high.
- START to WAIT_HI exit: set by the sorter. srt_ready falls the cycle after srt_start, and rises one cycle after the sorter returns to idle.
- Readback: 3 cycles per word with out_ready held high.
  - The first out_valid rises 2 cycles after WAIT_HI exits.
- Backpressure: any number of cycles with out_ready=0 holds out_data and out_valid unchanged.
- Reset mid-operation, in any state: state, counters and all outputs return to reset values immediately. The partially loaded or sorted batch is discarded, and the next batch starts at address 0.
- Duplicate values are legal. Equal bytes emerge adjacently.

## Configuration
- SORT_CHECK_EN defined:
  - An 8-bit prev register and a comparator are compiled in.
  - On each output handshake with rcnt>0, if out_data < prev then err <= 1.
  - prev <= out_data on every output handshake.
  - err is sticky and clears only in START or on reset.
- SORT_CHECK_EN undefined: no prev register or comparator; err is tied to 0.

## Test plan
- Reset with srt_ready=1 → in_ready=1; out_valid, busy, srt_wr, srt_start and err all 0.
- Load 5,3,7,1,8,2,6,4 back-to-back with the real sorter attached:
  - srt_wr on 8 consecutive cycles at addresses 0..7;
  - srt_start pulses once;
  - the output stream is 1,2,3,4,5,6,7,8;
  - busy falls after the 8th handshake;
  - err=0.
- Load 0xFF ×8 with in_valid gaps of 2 cycles → srt_wr asserted only on handshake cycles, addresses contiguous 0..7; output is 0xFF ×8.
- Hold out_ready=0 for 5 cycles at word index 3 → out_valid stays 1 and out_data stays 4 throughout; the sequence resumes with 5.
- Assert nrst during WAIT_HI → immediate return to LOAD with out_valid=0 and busy=0; a following batch 8,7,6,5,4,3,2,1 outputs 1..8.
- SORT_CHECK_EN defined, with a behavioral sorter model returning 2,1,3,4,5,6,7,8 → err rises at the 2nd output handshake, stays 1 through the batch, and clears in the next START.
